// File: rtl/shift_ops_pkg.sv
// Shared definitions for the shift/rotate sequencer: op codes, FSM state
// encoding and the effective-count rule applied when an operation is accepted.
package shift_ops_pkg;

  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHRA = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_ROL);
  endfunction

  // Shifts saturate at the data width; rotates wrap; illegal ops take no steps.
  function automatic logic [31:0] eff_count(input logic [2:0]  op,
                                            input logic [31:0] amount,
                                            input logic [31:0] width);
    logic [31:0] n;
    n = '0;
    case (op)
      OP_SHR, OP_SHRA, OP_SHL: n = (amount > width) ? width : amount;
      OP_ROR, OP_ROL:          n = amount % width;
      default:                 n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate stage: combinational (op, r) -> next r.
module shift_step
  import shift_ops_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_next
);

  always_comb begin
    r_next = r;
    case (op)
      OP_SHR:  r_next = {1'b0, r[WIDTH-1:1]};
      OP_SHRA: r_next = {r[WIDTH-1], r[WIDTH-1:1]};
      OP_SHL:  r_next = {r[WIDTH-2:0], 1'b0};
      OP_ROR:  r_next = {r[0], r[WIDTH-1:1]};
      OP_ROL:  r_next = {r[WIDTH-2:0], r[WIDTH-1]};
      default: r_next = r;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller: steps a 1-bit shift stage once per clock
// under an IDLE -> SHIFT -> DONE -> IDLE state machine.
module shift_sequencer
  import shift_ops_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [31:0]      shift_amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             op_err,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only in IDLE; busy is high from the cycle after
  // accept through the done cycle; done is a one-cycle pulse with result valid.
  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             op_err_q, op_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_eff;
  logic [WIDTH-1:0] step_out;

  assign n_eff = CNT_W'(eff_count(op, shift_amount, 32'(WIDTH)));

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op     (op_q),
    .r      (work_q),
    .r_next (step_out)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    result_d = result_q;
    op_err_d = op_err_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d     = op;
          work_d   = data_in;
          cnt_d    = n_eff;
          op_err_d = !is_legal_op(op);
          if (n_eff == '0) begin
            state_d  = ST_DONE;
            result_d = data_in;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_d = step_out;
        cnt_d  = cnt_q - CNT_W'(1);
        // Last step: the stepped value goes straight into result.
        if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_DONE;
          result_d = step_out;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      work_q   <= '0;
      result_q <= '0;
      op_err_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      result_q <= result_d;
      op_err_q <= op_err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign op_err    = op_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed and random operations,
// start-ignore, mid-shift reset and back-to-back streaming.
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [31:0] shift_amount;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        op_err;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_lat_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d;
    logic [31:0] amt;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  shift_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op           (op),
    .data_in      (data_in),
    .shift_amount (shift_amount),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .op_err       (op_err),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] d,
                                            input logic [31:0] amt);
    int k;
    case (o)
      3'd0: return (amt >= 32) ? 32'h0 : (d >> amt);
      3'd1: return (amt >= 32) ? {32{d[31]}} : 32'($signed(d) >>> amt);
      3'd2: return (amt >= 32) ? 32'h0 : (d << amt);
      3'd3: begin k = int'(amt % 32); return (k == 0) ? d : ((d >> k) | (d << (32 - k))); end
      3'd4: begin k = int'(amt % 32); return (k == 0) ? d : ((d << k) | (d >> (32 - k))); end
      default: return d;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] amt);
    if (o <= 3'd2) return (amt >= 32) ? 33 : int'(amt) + 1;
    if (o <= 3'd4) return int'(amt % 32) + 1;
    return 1;
  endfunction

  // driver tasks
  task automatic drive_op(input logic [2:0] o, input logic [31:0] d, input logic [31:0] amt);
    @(negedge clk);
    start        = 1'b1;
    op           = o;
    data_in      = d;
    shift_amount = amt;
    @(posedge clk);
  endtask

  task automatic wait_done(output int lat, output bit busy_ok, output bit got);
    lat = 0; busy_ok = 1'b1; got = 1'b0;
    while (lat < 100) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done === 1'b1) begin got = 1'b1; break; end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; op = 3'd2; data_in = 32'h5; shift_amount = 32'd1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, op_err, dbg_state} !== 5'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b op_err=%b state=%0d result=%h, want all 0",
               busy, done, op_err, dbg_state, result);
    end
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_start_dropped: busy=%b state=%0d, want 0/0", busy, dbg_state);
    end
  endtask

  task automatic test_ops();
    vec_t vecs[$];
    vec_t v;
    int lat; bit busy_ok; bit got;
    logic [31:0] er; logic ee; int el;
    vecs.push_back('{3'd1, 32'hFFFFFFFA, 32'd1,  32'hFFFFFFFD, 1'b0, 2});
    vecs.push_back('{3'd0, 32'h00000005, 32'd3,  32'h00000000, 1'b0, 4});
    vecs.push_back('{3'd0, 32'h80000000, 32'd40, 32'h00000000, 1'b0, 33});
    vecs.push_back('{3'd4, 32'h80000001, 32'd4,  32'h00000018, 1'b0, 5});
    vecs.push_back('{3'd3, 32'h00000003, 32'd33, 32'h80000001, 1'b0, 2});
    vecs.push_back('{3'd2, 32'h00001234, 32'd0,  32'h00001234, 1'b0, 1});
    vecs.push_back('{3'd6, 32'hCAFEBABE, 32'd7,  32'hCAFEBABE, 1'b1, 1});
    vecs.push_back('{3'd1, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0, 32});
    vecs.push_back('{3'd1, 32'h40000000, 32'd32, 32'h00000000, 1'b0, 33});
    vecs.push_back('{3'd4, 32'h12345678, 32'd32, 32'h12345678, 1'b0, 1});
    vecs.push_back('{3'd2, 32'h00000001, 32'd31, 32'h80000000, 1'b0, 32});
    for (int i = 0; i < 10; i++) begin
      v.op  = 3'($urandom_range(0, 7));
      v.d   = $urandom;
      v.amt = (i == 9) ? $urandom : 32'($urandom_range(0, 40));
      v.res = model_res(v.op, v.d, v.amt);
      v.err = (v.op > 3'd4);
      v.lat = model_lat(v.op, v.amt);
      vecs.push_back(v);
    end
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].res);
      exp_err_q.push_back(vecs[i].err);
      exp_lat_q.push_back(vecs[i].lat);
      drive_op(vecs[i].op, vecs[i].d, vecs[i].amt);
      wait_done(lat, busy_ok, got);
      er = exp_q.pop_front(); ee = exp_err_q.pop_front(); el = exp_lat_q.pop_front();
      checks++;
      if (!got || lat != el) begin
        failures++;
        $display("FAIL op%0d_latency: op=%0d amt=%0d got=%0d lat=%0d, want lat=%0d",
                 i, vecs[i].op, vecs[i].amt, got, lat, el);
      end
      checks++;
      if (result !== er || op_err !== ee) begin
        failures++;
        $display("FAIL op%0d_result: op=%0d d=%h amt=%0d result=%h op_err=%b, want %h/%b",
                 i, vecs[i].op, vecs[i].d, vecs[i].amt, result, op_err, er, ee);
      end
      checks++;
      if (!busy_ok || busy !== 1'b1) begin
        failures++;
        $display("FAIL op%0d_busy: busy_during_op_ok=%b busy_at_done=%b, want 1/1", i, busy_ok, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== er) begin
        failures++;
        $display("FAIL op%0d_after_done: done=%b busy=%b result=%h, want 0/0/%h", i, done, busy, result, er);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat; int extra; bit got;
    logic [31:0] er;
    exp_q.push_back(32'h00000400);
    drive_op(3'd2, 32'h1, 32'd10);
    lat = 0; got = 1'b0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin start = 1'b1; op = 3'd3; data_in = 32'hDEAD; shift_amount = 32'd5; end
      else if (lat == 1 || lat == 5) start = 1'b0;
      if (done === 1'b1) begin got = 1'b1; break; end
    end
    start = 1'b0;
    er = exp_q.pop_front();
    checks++;
    if (!got || lat != 11 || result !== er) begin
      failures++;
      $display("FAIL start_ignored_result: got=%0d lat=%0d result=%h, want lat=11 result=%h", got, lat, result, er);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || result !== er) begin
      failures++;
      $display("FAIL start_ignored_extra_done: extra_done=%0d result=%h, want 0/%h", extra, result, er);
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat; int extra; bit busy_ok; bit got;
    logic [31:0] er;
    drive_op(3'd1, 32'h80000000, 32'd20);
    repeat (5) begin @(negedge clk); start = 1'b0; end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset_state: busy=%b done=%b result=%h state=%0d, want 0/0/0/0",
               busy, done, result, dbg_state);
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL mid_reset_no_done: done_pulses=%0d, want 0", extra);
    end
    exp_q.push_back(model_res(3'd1, 32'hFFFFFFF8, 32'd2));
    drive_op(3'd1, 32'hFFFFFFF8, 32'd2);
    wait_done(lat, busy_ok, got);
    er = exp_q.pop_front();
    checks++;
    if (!got || lat != 3 || result !== er || result !== 32'hFFFFFFFE) begin
      failures++;
      $display("FAIL mid_reset_recover: lat=%0d result=%h, want 3/FFFFFFFE", lat, result);
    end
  endtask

  task automatic test_back_to_back();
    int idx; int last; int n_done;
    logic [31:0] er;
    repeat (3) exp_q.push_back(32'd12);
    @(negedge clk);
    start = 1'b1; op = 3'd2; data_in = 32'd3; shift_amount = 32'd2;
    idx = 0; last = 0; n_done = 0;
    while (idx < 40 && n_done < 3) begin
      @(negedge clk);
      idx++;
      if (done === 1'b1) begin
        er = exp_q.pop_front();
        checks++;
        if (result !== er) begin
          failures++;
          $display("FAIL b2b_result%0d: result=%h, want %h", n_done, result, er);
        end
        if (n_done > 0) begin
          checks++;
          if (idx - last != 4) begin
            failures++;
            $display("FAIL b2b_spacing%0d: spacing=%0d, want 4", n_done, idx - last);
          end
        end
        last = idx;
        n_done++;
      end
    end
    start = 1'b0;
    checks++;
    if (n_done != 3) begin
      failures++;
      $display("FAIL b2b_count: done_pulses=%0d, want 3", n_done);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; op = '0; data_in = '0; shift_amount = '0;
    test_reset();
    test_ops();
    test_start_ignored();
    test_reset_mid_shift();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
